// File: rtl/unssub_pkg.sv
// Shared definitions for the unary-subtractor scheduler: FSM encoding and width helpers.
package unssub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A window of 2^DW samples can be all ones, so the count needs one extra bit.
  function automatic int res_width(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/unssub_rr_arb.sv
// Combinational NREQ-way round-robin arbiter: grants the first request at or after ptr_i.
module unssub_rr_arb
  import unssub_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/unssub_sched.sv
// Time-multiplexes one unary subtractor among NREQ requesters: round-robin grant, counter SNG
// driving A/B for 2^DW cycles, then counts ones on the returned C stream.
module unssub_sched
  import unssub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int PIPE = 2,
  localparam int IW   = clog2(NREQ),
  localparam int RESW = res_width(DW)
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic [NREQ-1:0]      iReq,
  input  logic [NREQ*DW-1:0]   iOpA,
  input  logic [NREQ*DW-1:0]   iOpB,
  output logic [NREQ-1:0]      oGnt,
  output logic                 oBusy,
  output logic                 oSubRstN,
  output logic                 oSubA,
  output logic                 oSubB,
  input  logic                 iSubC,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [RESW-1:0]      oResult,
  output logic [IW-1:0]        oResId,
  output logic [2:0]           oDbgState
);

  localparam logic [DW-1:0] N_LAST = '1;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, id_q, ptr_d;
  logic [DW-1:0]   opa_q, opb_q, n_q, n_d, n_rev;
  logic [RESW-1:0] res_q;
  logic            sub_rst_n_q, sub_a_q, sub_b_q, valid_q;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [PIPE:0]   en_chain;
  logic            samp_en;

  unssub_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);

  // n_d is the window index whose bits go out on the streams next cycle.
  always_comb begin
    n_d   = (state_q == ST_RUN) ? n_q + DW'(1) : '0;
    n_rev = '0;
    for (int i = 0; i < DW; i++) n_rev[i] = n_d[DW-1-i];
  end

  // Stream bits reach iSubC PIPE cycles after they leave, so the sample window trails RUN.
  assign en_chain[0] = (state_q == ST_RUN);
  generate
    if (PIPE > 0) begin : g_dly
      logic [PIPE-1:0] dly_q;
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= en_chain[0];
          for (int k = 1; k < PIPE; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign en_chain[PIPE:1] = dly_q;
    end
  endgenerate
  assign samp_en = en_chain[PIPE];

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      n_q         <= '0;
      res_q       <= '0;
      sub_rst_n_q <= 1'b0;
      sub_a_q     <= 1'b0;
      sub_b_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q <= ST_CLEAR;
            opa_q   <= iOpA[arb_idx*DW +: DW];
            opb_q   <= iOpB[arb_idx*DW +: DW];
            id_q    <= arb_idx;
            ptr_q   <= ptr_d;
            n_q     <= '0;
            res_q   <= '0;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_RUN;
          sub_rst_n_q <= 1'b1;
          sub_a_q     <= (n_d < opa_q);
          sub_b_q     <= (n_rev < opb_q);
          n_q         <= n_d;
        end
        ST_RUN: begin
          if (n_q == N_LAST) begin
            sub_a_q <= 1'b0;
            sub_b_q <= 1'b0;
            n_q     <= '0;
            state_q <= (PIPE == 0) ? ST_DONE : ST_DRAIN;
            valid_q <= (PIPE == 0);
          end else begin
            sub_a_q <= (n_d < opa_q);
            sub_b_q <= (n_rev < opb_q);
            n_q     <= n_d;
          end
        end
        ST_DRAIN: begin
          // The window counter is reused to time the drain.
          if (n_q == DW'(PIPE - 1)) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end else begin
            n_q <= n_q + DW'(1);
          end
        end
        ST_DONE: begin
          if (iReady) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            sub_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (samp_en) res_q <= res_q + RESW'(iSubC);
    end
  end

  assign oGnt      = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign oBusy     = (state_q != ST_IDLE);
  assign oSubRstN  = sub_rst_n_q;
  assign oSubA     = sub_a_q;
  assign oSubB     = sub_b_q;
  assign oValid    = valid_q;
  assign oResult   = res_q;
  assign oResId    = id_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_unssub_sched.sv
// Bench for unssub_sched: directed and random jobs, round-robin and result scoreboard.
module tb_unssub_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int PIPE = 2;
  localparam int LAT  = 1 + (1 << DW) + PIPE + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  iReq;
  logic [31:0] iOpA, iOpB;
  logic [3:0]  oGnt;
  logic        oBusy, oSubRstN, oSubA, oSubB, iSubC, oValid, iReady;
  logic [8:0]  oResult;
  logic [1:0]  oResId;
  logic [2:0]  dbg_state;
  logic [7:0]  op_a[4], op_b[4];

  always_comb begin
    iOpA = '0;
    iOpB = '0;
    for (int k = 0; k < NREQ; k++) begin
      iOpA[k*8 +: 8] = op_a[k];
      iOpB[k*8 +: 8] = op_b[k];
    end
  end

  unssub_sched #(.NREQ(NREQ), .DW(DW), .PIPE(PIPE)) dut (
    .iClk(clk), .iRstN(rst_n), .iReq(iReq), .iOpA(iOpA), .iOpB(iOpB),
    .oGnt(oGnt), .oBusy(oBusy), .oSubRstN(oSubRstN), .oSubA(oSubA), .oSubB(oSubB),
    .iSubC(iSubC), .oValid(oValid), .iReady(iReady), .oResult(oResult),
    .oResId(oResId), .oDbgState(dbg_state)
  );

  // Datapath model: C = A & ~B, PIPE cycles late, cleared by oSubRstN.
  logic [PIPE-1:0] dp_q;
  always @(posedge clk) begin
    if (!oSubRstN) dp_q <= '0;
    else           dp_q <= {dp_q[PIPE-2:0], oSubA & ~oSubB};
  end
  assign iSubC = dp_q[PIPE-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];
  int gnt_log[$];
  int gnt_count = 0;
  int mdl_ptr = 0;
  bit mdl_busy = 0;
  int grant_cyc = 0;
  bit prev_hold = 0;
  bit valid_prev = 0;
  logic [8:0] hold_res;
  logic [1:0] hold_id;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference: A bit n is (n < a); B bit n is (bitrev(n) < b); count n where A=1 and B=0.
  function automatic int model_result(input int a, input int b);
    int cnt;
    logic [7:0] n8, r8;
    cnt = 0;
    for (int n = 0; n < 256; n++) begin
      n8 = 8'(n);
      for (int i = 0; i < 8; i++) r8[i] = n8[7-i];
      if (n < a && !(int'(r8) < b)) cnt++;
    end
    return cnt;
  endfunction

  // ---------------- monitor ----------------
  int pick;
  logic [3:0] exp_gnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_busy   = 0;
      mdl_ptr    = 0;
      prev_hold  = 0;
      valid_prev = 0;
    end else begin
      pick    = rr_pick(iReq, mdl_ptr);
      exp_gnt = (!mdl_busy && pick >= 0) ? (4'b0001 << pick) : 4'b0000;
      check("gnt", oGnt, exp_gnt);
      check("busy", oBusy, mdl_busy);
      if (prev_hold) begin
        check("hold_valid", oValid, 1);
        check("hold_result", oResult, hold_res);
        check("hold_id", oResId, hold_id);
      end
      if (oValid && !valid_prev) check("latency", cyc - grant_cyc, LAT);
      if (exp_gnt != 0) begin
        exp_q.push_back({2'(pick), 9'(model_result(op_a[pick], op_b[pick]))});
        gnt_log.push_back(int'(exp_gnt));
        grant_cyc = cyc;
        mdl_busy  = 1;
        mdl_ptr   = (pick + 1) % NREQ;
        gnt_count++;
      end
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("result", oResult, e[8:0]);
          check("res_id", oResId, e[10:9]);
        end
        mdl_busy = 0;
      end
      prev_hold  = oValid && !iReady;
      hold_res   = oResult;
      hold_id    = oResId;
      valid_prev = oValid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    check({tag, "_gnt"}, oGnt, 0);
    check({tag, "_busy"}, oBusy, 0);
    check({tag, "_subrstn"}, oSubRstN, 0);
    check({tag, "_suba"}, oSubA, 0);
    check({tag, "_subb"}, oSubB, 0);
    check({tag, "_valid"}, oValid, 0);
    check({tag, "_result"}, oResult, 0);
    check({tag, "_resid"}, oResId, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int target, input int budget);
    for (int i = 0; i < budget && gnt_count < target; i++) @(posedge clk);
    #1;
    if (gnt_count < target) check("gnt_timeout", gnt_count, target);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (mdl_busy || exp_q.size() != 0); i++) begin
      @(posedge clk); #1;
      if (rand_ready) iReady = ($urandom_range(0, 3) != 0);
    end
    iReady = 1'b1;
    if (mdl_busy || exp_q.size() != 0) check("idle_timeout", 0, 1);
  endtask

  task automatic single_job(input int k, input int a, input int b);
    @(posedge clk); #1;
    op_a[k] = 8'(a);
    op_b[k] = 8'(b);
    iReq[k] = 1'b1;
    wait_gnt(gnt_count + 1, 50);
    iReq = '0;
    op_a[k] = 8'($urandom);
    op_b[k] = 8'($urandom);
    wait_idle(600);
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = 8'($urandom);
      op_b[k] = 8'($urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_seq[5];
    exp_seq = '{1, 2, 4, 8, 1};
    rst_n  = 1'b0;
    iReq   = '0;
    iReady = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst_n = 1'b1;

    // Single requester, full A, empty B.
    gnt_log.delete();
    single_job(0, 255, 0);
    check("t1_gnt", gnt_log[0], 1);

    // Operand corners.
    single_job(0, 0, 0);
    single_job(0, 128, 0);
    single_job(0, 128, 255);

    // All requesters held: rotation from pointer 0.
    apply_reset();
    gnt_log.delete();
    randomize_ops();
    iReq = 4'hf;
    wait_gnt(gnt_count + 5, 2000);
    iReq = '0;
    wait_idle(600);
    for (int i = 0; i < 5; i++) check("t3_seq", gnt_log[i], exp_seq[i]);

    // Back-pressure in DONE with another request pending.
    @(posedge clk); #1;
    iReady  = 1'b0;
    op_a[1] = 8'($urandom);
    op_b[1] = 8'($urandom);
    iReq    = 4'b0010;
    wait_gnt(gnt_count + 1, 50);
    op_a[2] = 8'($urandom);
    op_b[2] = 8'($urandom);
    iReq    = 4'b0100;
    for (int i = 0; i < 400 && !oValid; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("t4_valid", oValid, 1);
    check("t4_busy", oBusy, 1);
    iReady = 1'b1;
    wait_gnt(gnt_count + 1, 5);
    check("t4_next_gnt", gnt_log[gnt_log.size()-1], 4);
    iReq = '0;
    wait_idle(600);

    // Reset in the middle of RUN, then the pointer must restart at 0.
    @(posedge clk); #1;
    iReq = 4'b0010;
    wait_gnt(gnt_count + 1, 50);
    iReq = '0;
    repeat (101) @(posedge clk);
    #1 check("t5_run", oSubRstN, 1);
    rst_n = 1'b0;
    #1 check_reset("mid");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    randomize_ops();
    iReq = 4'hf;
    wait_gnt(gnt_count + 1, 50);
    iReq = '0;
    check("t5_gnt", gnt_log[gnt_log.size()-1], 1);
    wait_idle(600);

    // Random masks, operands and consumer back-pressure.
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      randomize_ops();
      iReq = 4'($urandom_range(1, 15));
      rand_ready = 1;
      wait_gnt(gnt_count + 1, 50);
      iReq = '0;
      wait_idle(800);
      rand_ready = 0;
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
